// File: rtl/tbird_input_cond.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tbird_input_cond
// Purpose  : Synchronise and debounce the left/right/hazard switches, then
//            produce the step-aligned CL code {L,R} and the step pulse.
// Option   : define TBIRD_LATCH_EN to latch short debounced presses until
//            the next CL load.
// Revision : 1.0 - initial release
// ============================================================================
module tbird_input_cond #(
  parameter int DB_CYCLES = 16,
  parameter int TICK_DIV  = 1000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
  output logic [1:0] CL,
  output logic       step,
  output logic [2:0] db_lvl
);

  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_t;

  // Bit order everywhere: [2]=hazard, [1]=left, [0]=right
  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db;
  logic [2:0]       w_db_nxt;
  logic [2:0]       w_src;
  logic [1:0]       w_next_cl;
  logic [1:0]       r_cl;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_step;

  assign w_raw = {hazard_sw, left_sw, right_sw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_db_nxt[gi] = r_db[gi];
      unique case (r_state)
        ST_STABLE: begin
          if (r_sync2[gi] != r_db[gi]) begin
            w_state_nxt = ST_CHECK;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        ST_CHECK: begin
          if (r_sync2[gi] == r_db[gi]) begin
            // glitch: input returned before the hold time elapsed
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt  = ST_STABLE;
            w_cnt_nxt    = '0;
            w_db_nxt[gi] = ~r_db[gi];
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_db <= '0;
    else        r_db <= w_db_nxt;
  end

  assign w_step = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_step) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + c_cnt_one;
  end

`ifdef TBIRD_LATCH_EN
  logic [2:0] w_rise;
  logic [2:0] r_sticky;

  assign w_rise = w_db_nxt & ~r_db;

  // A rise on the load edge itself must survive, so set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_sticky <= '0;
    else if (w_step) r_sticky <= w_rise | (r_sticky & r_db);
    else             r_sticky <= r_sticky | w_rise;
  end

  assign w_src = r_db | r_sticky;
`else
  assign w_src = r_db;
`endif

  assign w_next_cl = (w_src[2] || (w_src[1] && w_src[0])) ? 2'b11
                                                          : {w_src[1], w_src[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cl <= 2'b00;
    else if (w_step) r_cl <= w_next_cl;
  end

  assign CL     = r_cl;
  assign step   = w_step;
  assign db_lvl = r_db;

endmodule
`default_nettype wire

// File: tb/tb_tbird_input_cond.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tbird_input_cond
// Purpose  : Directed self-checking bench for tbird_input_cond
//            (DB_CYCLES=4, TICK_DIV=8). ec = clk edges since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tbird_input_cond;

  localparam int DB_CYCLES = 4;
  localparam int TICK_DIV  = 8;
  localparam int CNT_W     = 16;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       left_sw   = 1'b0;
  logic       right_sw  = 1'b0;
  logic       hazard_sw = 1'b0;
  logic [1:0] CL;
  logic       step;
  logic [2:0] db_lvl;

  int ec       = 0;
  int n_checks = 0;
  int n_errors = 0;

  tbird_input_cond #(
    .DB_CYCLES (DB_CYCLES),
    .TICK_DIV  (TICK_DIV),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .left_sw   (left_sw),
    .right_sw  (right_sw),
    .hazard_sw (hazard_sw),
    .CL        (CL),
    .step      (step),
    .db_lvl    (db_lvl)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (ec=%0d)", tag, got, exp, ec);
    end
  endtask

  // Returns at the falling edge following edge n; an expired bound is a failure.
  task automatic wait_ec(input int n);
    int guard;
    guard = 0;
    while (ec < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (ec != n) check_val("wait_ec", 16'(ec), 16'(n));
  endtask

`ifdef TBIRD_LATCH_EN
  localparam logic [1:0] c_pulse_cl = 2'b01;
`else
  localparam logic [1:0] c_pulse_cl = 2'b00;
`endif

  initial begin
    // Reset held with every switch on
    reset = 1'b0; left_sw = 1'b1; right_sw = 1'b1; hazard_sw = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_cl",   16'(CL),     16'h0);
    check_val("rst_step", 16'(step),   16'h0);
    check_val("rst_db",   16'(db_lvl), 16'h0);
    left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;
    reset = 1'b1;

    // First step in the 8th period counting the release period as the first
    for (int i = 1; i <= 9; i++) begin
      logic exp_step;
      @(negedge clk);
      exp_step = ((i % TICK_DIV) == (TICK_DIV - 1));
      check_val("tick_step", 16'(step), 16'(exp_step));
    end

    // Clean left press: db after DB_CYCLES+2 edges, CL after next step
    wait_ec(10);  left_sw = 1'b1;
    wait_ec(15);  check_val("left_db_early", 16'(db_lvl), 16'h0);
    wait_ec(16);  check_val("left_db",       16'(db_lvl), 16'h2);
                  check_val("left_cl_wait",  16'(CL),     16'h0);
    wait_ec(23);  check_val("left_step",     16'(step),   16'h1);
                  check_val("left_cl_pre",   16'(CL),     16'h0);
    wait_ec(24);  check_val("left_cl",       16'(CL),     16'h2);

    // Priority: L+R, then hazard, then drop left, then release all
    right_sw = 1'b1;
    wait_ec(31);  check_val("lr_cl_pre",  16'(CL),     16'h2);
    wait_ec(32);  check_val("lr_db",      16'(db_lvl), 16'h3);
                  check_val("lr_cl",      16'(CL),     16'h3);
    hazard_sw = 1'b1;
    wait_ec(38);  check_val("hz_db",      16'(db_lvl), 16'h7);
    left_sw = 1'b0;
    wait_ec(40);  check_val("hz_cl",      16'(CL),     16'h3);
    wait_ec(44);  check_val("hz_noleft_db", 16'(db_lvl), 16'h5);
    wait_ec(48);  check_val("hz_noleft_cl", 16'(CL),   16'h3);
    right_sw = 1'b0; hazard_sw = 1'b0;
    wait_ec(54);  check_val("off_db",     16'(db_lvl), 16'h0);
    wait_ec(55);  check_val("off_cl_pre", 16'(CL),     16'h3);
    wait_ec(56);  check_val("off_cl",     16'(CL),     16'h0);

    // Bounce 1,0,1,0 on right: must be rejected
    right_sw = 1'b1;
    wait_ec(57);  right_sw = 1'b0;
    wait_ec(58);  right_sw = 1'b1;
    wait_ec(59);  right_sw = 1'b0;
    for (int k = 60; k <= 72; k++) begin
      wait_ec(k);
      check_val("bounce_db", 16'(db_lvl), 16'h0);
    end
    check_val("bounce_cl", 16'(CL), 16'h0);

    // db rise lands in the step cycle: included in that load
    wait_ec(73);  right_sw = 1'b1;
    wait_ec(78);  check_val("sim_db_early", 16'(db_lvl), 16'h0);
    wait_ec(79);  check_val("sim_db",       16'(db_lvl), 16'h1);
                  check_val("sim_step",     16'(step),   16'h1);
                  check_val("sim_cl_pre",   16'(CL),     16'h0);
    wait_ec(80);  check_val("sim_cl",       16'(CL),     16'h1);
    right_sw = 1'b0;
    wait_ec(88);  check_val("sim_cl_off",   16'(CL),     16'h0);

    // db rise one cycle later: waits a whole step period
    wait_ec(90);  right_sw = 1'b1;
    wait_ec(96);  check_val("late_db",      16'(db_lvl), 16'h1);
                  check_val("late_cl0",     16'(CL),     16'h0);
    wait_ec(103); check_val("late_step",    16'(step),   16'h1);
                  check_val("late_cl_pre",  16'(CL),     16'h0);
    wait_ec(104); check_val("late_cl",      16'(CL),     16'h1);
    right_sw = 1'b0;
    wait_ec(112); check_val("late_cl_off",  16'(CL),     16'h0);

    // 5-cycle right pulse entirely between two loads
    wait_ec(114); right_sw = 1'b1;
    wait_ec(119); right_sw = 1'b0;
    wait_ec(120); check_val("pulse_db",     16'(db_lvl), 16'h1);
                  check_val("pulse_cl0",    16'(CL),     16'h0);
    wait_ec(125); check_val("pulse_db_off", 16'(db_lvl), 16'h0);
    wait_ec(127); check_val("pulse_cl_pre", 16'(CL),     16'h0);
    wait_ec(128); check_val("pulse_cl",     16'(CL),     16'(c_pulse_cl));
    wait_ec(135); check_val("pulse_cl_hold", 16'(CL),    16'(c_pulse_cl));
    wait_ec(136); check_val("pulse_cl_end", 16'(CL),     16'h0);

    // Reset in mid-operation with a partial right debounce in flight
    left_sw = 1'b1;
    wait_ec(144); check_val("mid_cl_pre",   16'(CL),     16'h2);
    wait_ec(145); right_sw = 1'b1;
    wait_ec(149);
    #2 reset = 1'b0;
    #1;
    check_val("mid_rst_cl",   16'(CL),     16'h0);
    check_val("mid_rst_step", 16'(step),   16'h0);
    check_val("mid_rst_db",   16'(db_lvl), 16'h0);
    left_sw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_ec(5);   check_val("rel_db_early", 16'(db_lvl), 16'h0);
    wait_ec(6);   check_val("rel_db",       16'(db_lvl), 16'h1);
    wait_ec(7);   check_val("rel_step",     16'(step),   16'h1);
                  check_val("rel_cl_pre",   16'(CL),     16'h0);
    wait_ec(8);   check_val("rel_cl",       16'(CL),     16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, ec=%0d", ec);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tbird_input_cond.md
Name: tbird_input_cond

Overview:
- Upstream conditioning stage for the tail-light sequencer.
- Takes raw left, right and hazard switch levels and synchronises and debounces each one.
- Merges them into the 2-bit CL code (CL[1]=L, CL[0]=R) and generates a slow step enable.
- CL changes only on step boundaries, so the sequencer sees one stable code per animation step.

Parameters:
- DB_CYCLES, 16, consecutive stable clk cycles a synchronised input must hold before its debounced level flips (>=2).
- TICK_DIV, 1000, clk cycles per step pulse (>=2).
- CNT_W, 16, width of the debounce and tick counters; must hold max(DB_CYCLES, TICK_DIV)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- left_sw  input  1  raw left switch, asynchronous, may bounce
- right_sw  input  1  raw right switch, asynchronous, may bounce
- hazard_sw  input  1  raw hazard switch, asynchronous, may bounce
- CL  output  2  conditioned code to sequencer: {L,R}
- step  output  1  one-clk pulse every TICK_DIV cycles
- db_lvl  output  3  debounced levels {hazard,left,right}, status only

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, debounce counters, debounced levels, tick counter, CL and step clear to 0. Release is sampled on the first clk edge with reset=1.
- Synchroniser: two-flop synchroniser per switch. Raw-to-sync latency is 2 clk.
- Debouncer, one per input, a 2-state FSM:
  - STABLE: counter=0. If the sync value differs from db level, go to CHECK with counter=1.
  - CHECK: if the sync value equals db level again, return to STABLE and clear the counter (glitch rejected). Otherwise increment the counter. When counter reaches DB_CYCLES-1 and sync still differs, toggle db level, clear the counter and go to STABLE.
  - Net: a clean edge appears on db level exactly DB_CYCLES+2 clk after the raw edge.
- Tick generator: the counter runs 0..TICK_DIV-1 and wraps. step=1 for the single cycle in which the counter equals TICK_DIV-1; otherwise 0. After reset, the first step occurs on cycle TICK_DIV.
- Code merge (combinational, "next_CL"):
  - hazard=1, or left=1 and right=1 -> 2'b11
  - left only -> 2'b10
  - right only -> 2'b01
  - none -> 2'b00
- CL register: loads next_CL only in the cycle where step=1; holds otherwise. The new CL is visible the cycle after the step pulse.
- Simultaneous events: a db toggle in the same cycle as step is included in that load, because next_CL is computed from the current db level after the toggle register updates. A toggle in the following cycle waits for the next step.
- Reset mid-operation: everything returns immediately to the reset values. Partial debounce counts are discarded.
- db_lvl mirrors the debounced registers with no delay.

Optional Feature:
- Macro: TBIRD_LATCH_EN
- Defined:
  - Each debounced rising edge of left, right or hazard sets a sticky request bit. next_CL is computed from (db level OR sticky).
  - Sticky bits clear in the cycle CL loads, unless that input's db level is still 1.
  - Effect: a press shorter than TICK_DIV but at least DB_CYCLES still produces one non-zero CL for one step.
- Undefined: no sticky bits; a press released before the next step is lost.

Test Plan (DB_CYCLES=4, TICK_DIV=8):
- Reset check: hold reset=0 with all switches=1 -> CL=00, step=0, db_lvl=000. Release -> first step pulse at cycle 8 after release.
- Clean left press at cycle 0: left_sw=1 held -> db_lvl[1]=1 at cycle 6. CL=10 the cycle after the first step pulse at or after cycle 6, held until left is released.
- Bounce: right_sw toggles 1,0,1,0 on consecutive cycles, then stays 0 -> db_lvl[0] never rises; CL stays 00.
- Priority: left and right both debounced high -> CL=11. Add hazard, then release left -> CL stays 11. Release all -> CL=00 at the next step after debounce.
- Simultaneity: arrange for db_lvl[0] to rise in exactly the step cycle -> CL=01 the next cycle. Shift the rise one cycle later -> CL=01 only 8 cycles later.
- TBIRD_LATCH_EN: 5-cycle right pulse between steps -> with macro, CL=01 for exactly one step period, then 00. Without macro, CL stays 00.
